// File: rtl/ddr_bringup_seq_if.sv
// Bring-up sequencer signal bundle: start/status, DDR hard-block resets,
// config-master handshake and per-port AXI resets.
interface ddr_bringup_seq_if #(
  parameter int NUM_AXI = 2
);
  logic               start;
  logic               ddr_pll_lock;
  logic               cfg_done;
  logic               ddr_pll_rstn;
  logic               phy_rstn;
  logic               ctrl_rstn;
  logic               cfg_sel;
  logic               cfg_start;
  logic               cfg_reset;
  logic [NUM_AXI-1:0] axi_aresetn;
  logic               ready;
  logic               fail;
  logic [3:0]         retry_cnt;
  logic [3:0]         state;

  modport master (
    input  start, ddr_pll_lock, cfg_done,
    output ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset,
           axi_aresetn, ready, fail, retry_cnt, state
  );

  modport slave (
    output start, ddr_pll_lock, cfg_done,
    input  ddr_pll_rstn, phy_rstn, ctrl_rstn, cfg_sel, cfg_start, cfg_reset,
           axi_aresetn, ready, fail, retry_cnt, state
  );
endinterface

// File: rtl/ddr_bringup_seq.sv
// LPDDR4 bring-up sequencer: PLL reset/lock, PHY/ctrl release, config, AXI release,
// with timeouts and bounded retry. Define DDR_SEQ_LOCK_MON_EN for PLL lock loss monitoring in READY.
module ddr_seq_axi_lane (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic rel,
  output logic aresetn
);
  always_ff @(posedge clk) begin
    if (rst || clr) aresetn <= 1'b0;
    else if (rel)   aresetn <= 1'b1;
  end
endmodule

module ddr_bringup_seq #(
  parameter int NUM_AXI      = 2,
  parameter int RST_HOLD_CYC = 16,
  parameter int PLL_LOCK_CYC = 64,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int MAX_RETRY    = 3
) (
  input  logic              regACLK,
  input  logic              regARESET,
  ddr_bringup_seq_if.master bus
);
  localparam int            CW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HOLD      = CW'(RST_HOLD_CYC);
  localparam logic [CW-1:0] HOLD_M1   = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] LOCK_M1   = CW'(PLL_LOCK_CYC - 1);
  localparam logic [CW-1:0] TO_M1     = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] AXI_N     = CW'(NUM_AXI);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PLL_RST  = 4'd1,
    S_PLL_WAIT = 4'd2,
    S_RST_REL  = 4'd3,
    S_CFG      = 4'd4,
    S_AXI_REL  = 4'd5,
    S_READY    = 4'd6,
    S_RETRY    = 4'd7,
    S_FAIL     = 4'd8
  } st_e;

  typedef struct packed {
    logic pll_rstn;
    logic phy_rstn;
    logic ctrl_rstn;
    logic cfg_sel;
    logic cfg_start;
    logic cfg_reset;
    logic ready;
    logic fail;
  } out_t;

  localparam out_t OUT_RST = '{pll_rstn: 1'b0, phy_rstn: 1'b0, ctrl_rstn: 1'b0,
                               cfg_sel: 1'b0, cfg_start: 1'b0, cfg_reset: 1'b1,
                               ready: 1'b0, fail: 1'b0};

  st_e                st_q, st_d;
  logic [CW-1:0]      cnt_q, cnt_d, lock_q, lock_d;
  logic [3:0]         retry_q, retry_d;
  out_t               out_q, out_d;
  logic               rel_en, axi_clr;
  logic [NUM_AXI-1:0] axi_rel, axi_q;
  logic               lock_loss;

`ifdef DDR_SEQ_LOCK_MON_EN
  // Lock must read low on two consecutive READY cycles; a lone glitch is ignored.
  logic lock_low_q;
  always_ff @(posedge regACLK) begin
    if (regARESET) lock_low_q <= 1'b0;
    else           lock_low_q <= (st_q == S_READY) && !bus.ddr_pll_lock;
  end
  assign lock_loss = lock_low_q && !bus.ddr_pll_lock;
`else
  assign lock_loss = 1'b0;
`endif

  always_ff @(posedge regACLK) begin
    if (regARESET) begin
      st_q    <= S_IDLE;
      cnt_q   <= '0;
      lock_q  <= '0;
      retry_q <= '0;
      out_q   <= OUT_RST;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    st_d = st_q;
    if (!bus.start && st_q != S_IDLE) st_d = S_IDLE;
    else begin
      case (st_q)
        S_IDLE:     if (bus.start) st_d = S_PLL_RST;
        S_PLL_RST:  if (cnt_q == HOLD_M1) st_d = S_PLL_WAIT;
        S_PLL_WAIT: begin
          if (bus.ddr_pll_lock && lock_q == LOCK_M1) st_d = S_RST_REL;
          else if (cnt_q == TO_M1)                   st_d = S_RETRY;
        end
        S_RST_REL:  if (cnt_q == HOLD) st_d = S_CFG;
        S_CFG: begin
          if (bus.cfg_done)        st_d = S_AXI_REL;
          else if (cnt_q == TO_M1) st_d = S_RETRY;
        end
        S_AXI_REL:  if (cnt_q == AXI_N) st_d = S_READY;
        S_READY:    if (lock_loss) st_d = S_RETRY;
        S_RETRY:    st_d = (retry_q == RETRY_MAX) ? S_FAIL : S_PLL_RST;
        S_FAIL:     st_d = S_FAIL;
        default:    st_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the transition.
  always_comb begin
    rel_en  = (st_q == S_AXI_REL) && (st_d == S_AXI_REL);
    axi_clr = !(st_d inside {S_AXI_REL, S_READY});
    cnt_d   = (st_d != st_q) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    lock_d  = '0;
    if (st_q == S_PLL_WAIT && st_d == S_PLL_WAIT && bus.ddr_pll_lock)
      lock_d = (lock_q == CNT_MAX) ? lock_q : lock_q + 1'b1;
    retry_d = retry_q;
    if (st_d == S_IDLE)                             retry_d = '0;
    else if (st_q == S_RETRY && st_d == S_PLL_RST) retry_d = retry_q + 4'd1;
    out_d           = OUT_RST;
    out_d.pll_rstn  = st_d inside {S_PLL_WAIT, S_RST_REL, S_CFG, S_AXI_REL, S_READY};
    out_d.phy_rstn  = st_d inside {S_RST_REL, S_CFG, S_AXI_REL, S_READY};
    out_d.cfg_sel   = st_d inside {S_CFG, S_AXI_REL, S_READY};
    out_d.ctrl_rstn = out_d.cfg_sel ||
                      (st_q == S_RST_REL && st_d == S_RST_REL && cnt_q >= HOLD_M1);
    out_d.cfg_reset = !out_d.cfg_sel;
    out_d.cfg_start = (st_d == S_CFG) && (st_q != S_CFG);
    out_d.ready     = st_d == S_READY;
    out_d.fail      = st_d == S_FAIL;
  end

  for (genvar i = 0; i < NUM_AXI; i++) begin : g_rel
    assign axi_rel[i] = rel_en && (cnt_q == CW'(i));
  end

  ddr_seq_axi_lane u_lane [NUM_AXI-1:0] (
    .clk     (regACLK),
    .rst     (regARESET),
    .clr     (axi_clr),
    .rel     (axi_rel),
    .aresetn (axi_q)
  );

  assign bus.ddr_pll_rstn = out_q.pll_rstn;
  assign bus.phy_rstn     = out_q.phy_rstn;
  assign bus.ctrl_rstn    = out_q.ctrl_rstn;
  assign bus.cfg_sel      = out_q.cfg_sel;
  assign bus.cfg_start    = out_q.cfg_start;
  assign bus.cfg_reset    = out_q.cfg_reset;
  assign bus.ready        = out_q.ready;
  assign bus.fail         = out_q.fail;
  assign bus.axi_aresetn  = axi_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.state        = st_q;
endmodule

// File: doc/ddr_bringup_seq.md
# ddr_bringup_seq

Parametrised LPDDR4 bring-up sequencer: it orders PLL reset, PLL lock qualification, PHY/controller reset release, controller configuration start/done, and per-port AXI reset release for up to four AXI ports. It adds configurable timeouts, bounded retry, and a failure flag. It sits in the `regACLK` domain between `tools_core` and the DDR hard block and replaces ad-hoc reset sequencing. All outputs are registered.

## Interface
Parameters:
- `NUM_AXI`, 2: number of AXI ports whose `ARESETn` is sequenced (1–4).
- `RST_HOLD_CYC`, 16: reset assertion/spacing interval in cycles (≥2).
- `PLL_LOCK_CYC`, 64: consecutive cycles `ddr_pll_lock` must be high to count as locked (≥1).
- `TIMEOUT_CYC`, 100000: per-phase timeout for PLL lock and config done (> `PLL_LOCK_CYC`).
- `MAX_RETRY`, 3: retries before FAIL (0–15).

Ports:
- `regACLK`  in  1  clock.
- `regARESET`  in  1  reset. Synchronous to `regACLK`, active-high.
- `start`  in  1  level. 1 = bring up and hold; 0 = shut down.
- `ddr_pll_lock`  in  1  PLL lock. Treated as synchronous.
- `cfg_done`  in  1  controller configuration complete.
- `ddr_pll_rstn`  out  1  PLL reset, active-low.
- `phy_rstn`  out  1  PHY reset, active-low.
- `ctrl_rstn`  out  1  controller reset, active-low.
- `cfg_sel`  out  1  selects the sequencer as config master.
- `cfg_start`  out  1  one-cycle config start pulse.
- `cfg_reset`  out  1  config engine reset, active-high.
- `axi_aresetn`  out  NUM_AXI  per-port AXI reset, active-low.
- `ready`  out  1  all ports released.
- `fail`  out  1  retries exhausted.
- `retry_cnt`  out  4  retries consumed.
- `state`  out  4  state encoding, for debug.

## Operation
- Reset and IDLE output values:
  - `ddr_pll_rstn`, `phy_rstn`, `ctrl_rstn`, `cfg_sel`, `cfg_start` = 0.
  - `cfg_reset` = 1.
  - `axi_aresetn` = 0.
  - `ready`, `fail`, `retry_cnt` = 0.
  - `state` = IDLE (0).
- State encodings: IDLE 0, PLL_RST 1, PLL_WAIT 2, RST_REL 3, CFG 4, AXI_REL 5, READY 6, RETRY 7, FAIL 8.
- IDLE: when `start`=1, go to PLL_RST. Clear the phase counter and `retry_cnt`.
- PLL_RST: hold `ddr_pll_rstn`=0 for `RST_HOLD_CYC` cycles. Then set `ddr_pll_rstn`=1 and go to PLL_WAIT.
- PLL_WAIT:
  - A lock counter increments while `ddr_pll_lock`=1 and clears to 0 on any low cycle.
  - When the lock counter reaches `PLL_LOCK_CYC`, go to RST_REL.
  - If the phase timer reaches `TIMEOUT_CYC` first, go to RETRY.
- RST_REL: set `phy_rstn`=1 on entry. Set `ctrl_rstn`=1 `RST_HOLD_CYC` cycles later. On the next cycle go to CFG.
- CFG:
  - Set `cfg_sel`=1 and `cfg_reset`=0 on entry.
  - `cfg_start`=1 for exactly the first cycle in CFG.
  - On `cfg_done`=1, go to AXI_REL.
  - If `TIMEOUT_CYC` elapses first, go to RETRY.
  - `cfg_done` seen in the entry cycle is accepted.
- AXI_REL: release one port per cycle, bit 0 first. After `NUM_AXI` cycles all bits are 1; go to READY.
- READY: `ready`=1. `cfg_sel` stays 1.
- RETRY (one cycle):
  - All outputs return to their reset values, except `retry_cnt`.
  - If `retry_cnt`==`MAX_RETRY`, go to FAIL.
  - Otherwise increment `retry_cnt` and go to PLL_RST.
- FAIL: `fail`=1; all reset outputs stay asserted.
- Shutdown: `start`=0 in any state other than IDLE (including FAIL) → IDLE on the next edge.
  - All outputs take their IDLE values on that edge; `axi_aresetn` drops simultaneously.
  - `fail` and `retry_cnt` clear.
- `regARESET` mid-sequence has the same effect as shutdown, but takes priority over every other condition.
- Counter width is `$clog2(TIMEOUT_CYC+1)` bits. Counters saturate and never wrap.

## Timing
- `start` is sampled at edge E0 (PLL_RST entered at E0). `ddr_pll_rstn` rises at E0+`RST_HOLD_CYC`.
- Lock held high from PLL_WAIT entry: RST_REL is entered `PLL_LOCK_CYC` edges after PLL_WAIT entry.
- `ctrl_rstn` rises `RST_HOLD_CYC` edges after `phy_rstn`. CFG is entered one edge later.
- `ready` rises `NUM_AXI`+1 edges after `cfg_done` is sampled.
- State, outputs and counters update only on the `regACLK` rising edge. No combinational input-to-output paths.

## Configuration
- `DDR_SEQ_LOCK_MON_EN` defined: in READY, `ddr_pll_lock`=0 for 2 consecutive cycles does the following:
  - `ready`=0 and `axi_aresetn`=0 on the next edge.
  - Go to RETRY, which follows the normal retry/FAIL rules.
  - A single-cycle glitch is ignored.
- `DDR_SEQ_LOCK_MON_EN` undefined: `ddr_pll_lock` is ignored outside PLL_WAIT.

## Test plan
Bench parameters: `NUM_AXI`=2, `RST_HOLD_CYC`=4, `PLL_LOCK_CYC`=8, `TIMEOUT_CYC`=100, `MAX_RETRY`=2.
- Nominal path: `start`=1 at E0, lock high from E3, `cfg_done` 5 cycles after `cfg_start`.
  - `ddr_pll_rstn` rises at E4; `cfg_start` is exactly one pulse.
  - `axi_aresetn` goes 00→01→11; `ready`=1, `retry_cnt`=0.
- Lock glitch: lock toggles low every 5 cycles → no exit from PLL_WAIT; timeout at 100 cycles → `retry_cnt`=1.
- `cfg_done` never asserted → 3 CFG timeouts → `fail`=1 with `retry_cnt`=2 and all resets asserted. Then `start`=0 → IDLE, `fail`=0.
- Shutdown mid-CFG: `start`=0 → on the next edge `state`=0 and all outputs equal reset values.
- Lock monitor (`DDR_SEQ_LOCK_MON_EN`): in READY, drop lock for 1 cycle → `ready` stays 1. Drop for 2 cycles → `ready`=0, `axi_aresetn`=00, `retry_cnt`=1.
- `regARESET`=1 asserted together with `cfg_done`=1 → reset wins; IDLE values next edge.
